// File: rtl/uart_rx_if.sv
// Receive-side output bundle of the UART receiver: received word, completion strobe and framing error.
// rx_done_tick is a one-clk valid pulse with no ready: the consumer must take dout/frame_err on that cycle.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (output dout, output rx_done_tick, output frame_err);
  modport slave  (input  dout, input  rx_done_tick, input  frame_err);
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: 2-flop rx synchronizer, start-bit validation at mid-bit,
// LSB-first data sampling, stop-bit check, and a registered one-clk completion strobe.
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        s_tick,
  uart_rx_if.master   rx_out,
  output logic [1:0]  dbg_state,
  output logic [5:0]  dbg_s,
  output logic [2:0]  dbg_n
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [5:0]      s_reg, s_next;
  logic [2:0]      n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            ferr_reg, ferr_next;
  logic            done_reg, done_next;
  logic            rx_meta, rx_s;

  // Synchronizer resets to the idle line level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
      ferr_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
      ferr_reg  <= ferr_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    dout_next  = dout_reg;
    ferr_next  = ferr_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // Leaving IDLE needs no tick so a zero-gap following frame is caught on its first clk.
        if (!rx_s) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == 6'd7) begin
            s_next = '0;
            if (!rx_s) begin
              state_next = DATA;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == 6'd15) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == 3'(DBIT - 1)) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 3'd1;
            end
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == 6'(SB_TICK - 1)) begin
            state_next = IDLE;
            s_next     = '0;
            dout_next  = b_reg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
          end else begin
            s_next = s_reg + 6'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_out.dout         = dout_reg;
  assign rx_out.rx_done_tick = done_reg;
  assign rx_out.frame_err    = ferr_reg;

  assign dbg_state = state_reg;
  assign dbg_s     = s_reg;
  assign dbg_n     = n_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, glitch, framing error, back-to-back frames,
// slow tick, tick freeze and mid-frame reset.
module tb_uart_rx;
  localparam int DBIT = 8;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [1:0] dbg_state;
  logic [5:0] dbg_s;
  logic [2:0] dbg_n;

  uart_rx_if #(.DBIT(DBIT)) rx_bus ();

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .s_tick    (s_tick),
    .rx_out    (rx_bus),
    .dbg_state (dbg_state),
    .dbg_s     (dbg_s),
    .dbg_n     (dbg_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tick_div = 1;
  int ph = 0;
  int tick_count = 0;
  bit tick_en = 1'b1;
  int done_cnt = 0;
  int width_err = 0;
  logic prev_done = 1'b0;
  int done_ticks[$];
  logic [DBIT-1:0] exp_q[$];
  logic [DBIT-1:0] got_q[$];

  always @(negedge clk) begin
    if (rx_bus.rx_done_tick) begin
      done_cnt++;
      done_ticks.push_back(tick_count);
      got_q.push_back(rx_bus.dout);
      if (prev_done) width_err++;
    end
    prev_done = rx_bus.rx_done_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_clk();
    s_tick = tick_en && (ph == 0);
    if (s_tick) tick_count++;
    ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n);
    int target;
    target = tick_count + n;
    while (tick_count < target) run_clk();
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx = 1'b0;
    run_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      run_ticks(16);
    end
    rx = stop;
    run_ticks(16);
    rx = 1'b1;
    exp_q.push_back(data);
  endtask

  task automatic check_sb(input string tag);
    logic [DBIT-1:0] e, g;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int d0;
    int n0;
    logic [7:0] f0;
    logic [7:0] f6;

    // reset state
    run_clk();
    run_clk();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_s", dbg_s, 0);
    check("rst_n", dbg_n, 0);
    check("rst_dout", rx_bus.dout, 0);
    check("rst_done", rx_bus.rx_done_tick, 0);
    check("rst_ferr", rx_bus.frame_err, 0);
    reset = 1'b1;
    run_ticks(20);

    // good frame 0xA5
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1);
    run_ticks(32);
    check("a5_done", done_cnt - d0, 1);
    check("a5_dout", rx_bus.dout, 8'hA5);
    check("a5_ferr", rx_bus.frame_err, 0);
    check_sb("a5_sb");

    // glitch: 4 ticks low
    d0 = done_cnt;
    rx = 1'b0;
    run_ticks(4);
    check("glitch_in_start", dbg_state, ST_START);
    check("glitch_s", dbg_s, 1);
    rx = 1'b1;
    run_ticks(12);
    check("glitch_idle", dbg_state, ST_IDLE);
    run_ticks(20);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_dout", rx_bus.dout, 8'hA5);

    // framing error then a good frame
    d0 = done_cnt;
    send_frame(8'h3C, 1'b0);
    run_ticks(32);
    check("ferr_done", done_cnt - d0, 1);
    check("ferr_dout", rx_bus.dout, 8'h3C);
    check("ferr_flag", rx_bus.frame_err, 1);
    d0 = done_cnt;
    send_frame(8'h55, 1'b1);
    run_ticks(32);
    check("ok55_done", done_cnt - d0, 1);
    check("ok55_dout", rx_bus.dout, 8'h55);
    check("ok55_ferr", rx_bus.frame_err, 0);
    check_sb("ferr_sb");

    // back-to-back with zero idle gap
    d0 = done_cnt;
    n0 = done_ticks.size();
    send_frame(8'h00, 1'b1);
    check("b2b_first_dout", rx_bus.dout, 8'h00);
    send_frame(8'hFF, 1'b1);
    run_ticks(32);
    check("b2b_done", done_cnt - d0, 2);
    check("b2b_dout", rx_bus.dout, 8'hFF);
    if (done_ticks.size() >= n0 + 2)
      check("b2b_spacing", done_ticks[n0 + 1] - done_ticks[n0], 160);
    else
      check("b2b_pulses", done_ticks.size() - n0, 2);
    check_sb("b2b_sb");

    // tick freeze mid-frame, frame 0x6B
    d0 = done_cnt;
    f6 = 8'h6B;
    rx = 1'b0;
    run_ticks(16);
    rx = f6[0];
    run_ticks(16);
    rx = f6[1];
    run_ticks(5);
    check("frz_state", dbg_state, ST_DATA);
    check("frz_s", dbg_s, 10);
    check("frz_n", dbg_n, 1);
    tick_en = 1'b0;
    repeat (100) run_clk();
    tick_en = 1'b1;
    check("frz_hold_state", dbg_state, ST_DATA);
    check("frz_hold_s", dbg_s, 10);
    check("frz_hold_n", dbg_n, 1);
    run_ticks(11);
    for (int i = 2; i < 8; i++) begin
      rx = f6[i];
      run_ticks(16);
    end
    rx = 1'b1;
    run_ticks(16);
    exp_q.push_back(f6);
    run_ticks(32);
    check("frz_done", done_cnt - d0, 1);
    check("frz_dout", rx_bus.dout, 8'h6B);
    check_sb("frz_sb");

    // slow tick: one tick every 4 clk
    tick_div = 4;
    ph = 0;
    d0 = done_cnt;
    send_frame(8'h81, 1'b1);
    run_ticks(32);
    check("div4_done", done_cnt - d0, 1);
    check("div4_dout", rx_bus.dout, 8'h81);
    check("div4_width", width_err, 0);
    check_sb("div4_sb");
    tick_div = 1;
    ph = 0;

    // reset during data bit 3 of 0xF0
    d0 = done_cnt;
    f0 = 8'hF0;
    rx = 1'b0;
    run_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = f0[i];
      run_ticks(16);
    end
    rx = f0[3];
    run_ticks(8);
    reset = 1'b0;
    run_clk();
    run_clk();
    check("mrst_state", dbg_state, ST_IDLE);
    check("mrst_s", dbg_s, 0);
    check("mrst_dout", rx_bus.dout, 0);
    check("mrst_ferr", rx_bus.frame_err, 0);
    rx = 1'b1;
    reset = 1'b1;
    run_ticks(200);
    check("mrst_no_strobe", done_cnt - d0, 0);
    check("mrst_idle", dbg_state, ST_IDLE);
    send_frame(8'h0F, 1'b1);
    run_ticks(32);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_dout", rx_bus.dout, 8'h0F);
    check("post_rst_ferr", rx_bus.frame_err, 0);
    check("final_width", width_err, 0);
    check_sb("post_rst_sb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that consumes the oversampling tick from the baud generator, running at 16 ticks per bit.
- Synchronizes the asynchronous serial input.
- Detects and validates the start bit.
- Samples data bits at mid-bit, LSB first, and checks the stop bit.
- Presents each received byte with a one-cycle done strobe to the downstream FIFO/consumer.

Parameters:
DBIT, 8, number of data bits per frame (5..8)
SB_TICK, 16, ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
rx  input  1  raw serial line, idle high, asynchronous to clk
s_tick  input  1  oversampling tick from baud_gen, one-clk pulse, 16 per bit
dout  output  DBIT  last received data word
rx_done_tick  output  1  one-clk pulse when a frame completes
frame_err  output  1  stop bit sampled low on last completed frame

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; s_reg, n_reg and b_reg cleared.
  - dout=0, rx_done_tick=0, frame_err=0.
  - Both synchronizer flops set to 1, the idle line level.
- Synchronizer: two flops on rx produce rx_s. Latency from rx to rx_s is 2 clk. All decisions use rx_s only.
- Counters:
  - s_reg is 6 bits and counts ticks within a bit.
  - n_reg is 3 bits and counts data bits.
  - b_reg is a DBIT-wide shift register.
- Counters and state advance only on clocks with s_tick=1, except the IDLE exit. If s_tick never pulses, the FSM freezes in place.
- IDLE:
  - When rx_s==0 (no tick required): go to START, s_reg=0.
  - Otherwise stay.
- START:
  - On s_tick with s_reg==7 (mid start bit):
    - rx_s==0: go to DATA, s_reg=0, n_reg=0.
    - rx_s==1: glitch; go to IDLE, no strobe, outputs unchanged.
  - Other ticks: s_reg+1.
- DATA:
  - On s_tick with s_reg==15: s_reg=0 and b_reg={rx_s, b_reg[DBIT-1:1]} (LSB first).
    - If n_reg==DBIT-1, go to STOP.
    - Else n_reg+1.
  - Other ticks: s_reg+1.
- STOP:
  - On s_tick with s_reg==SB_TICK-1:
    - dout<=b_reg.
    - frame_err<=~rx_s.
    - rx_done_tick<=1 for exactly the following clk cycle.
    - Go to IDLE, s_reg=0.
  - Other ticks: s_reg+1.
- rx_done_tick is registered and high for exactly one clk per completed frame, including frames with frame_err=1.
- dout and frame_err hold their value until the next completed frame. An aborted (glitch) frame never changes them.
- A new start edge is accepted on the first clk in IDLE. Back-to-back frames with zero idle gap must both be received.
- rx going low while in DATA or STOP has no effect other than being sampled.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is discarded and produces no strobe.
- Total latency: stop-bit completion tick edge to rx_done_tick high is 1 clk.

Test Plan:
- Drive s_tick every clk and send frame 0xA5 (start, 1,0,1,0,0,1,0,1 LSB first, stop=1) at 16 ticks/bit -> exactly one rx_done_tick pulse, dout=0xA5, frame_err=0.
- Glitch: rx low for 4 ticks then high -> FSM returns to IDLE at tick 8, no rx_done_tick, dout keeps prior value.
- Framing error: send 0x3C with stop bit=0 -> rx_done_tick=1 once, dout=0x3C, frame_err=1. A following good 0x55 frame gives frame_err=0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses 160 ticks apart, dout=0x00 then 0xFF.
- Drive s_tick every 4 clk (baud_gen divisor case) with frame 0x81 -> dout=0x81; rx_done_tick still exactly 1 clk wide.
- Assert reset low at data bit 3 of 0xF0, release, then send 0x0F -> no strobe for the aborted frame, dout=0x0F after the second frame, frame_err=0. Also hold s_tick=0 mid-frame for 100 clk -> state, s_reg and n_reg unchanged.
